// File: rtl/mlp_defs_pkg.sv
// Shared layer/phase codes for the MLP controller and the wrapper around it.
// curr_layer carries the FSM state code directly, so the state enum reuses
// the same 3-bit values the wrapper compares against.
package mlp_defs;

   localparam logic [2:0] LAYER_IDLE   = 3'd0;
   localparam logic [2:0] LAYER_FETCH  = 3'd1;
   localparam logic [2:0] LAYER_HIDDEN = 3'd2;
   localparam logic [2:0] LAYER_OUTPUT = 3'd3;
   localparam logic [2:0] LAYER_ARGMAX = 3'd4;
   localparam logic [2:0] LAYER_SCORE  = 3'd5;
   localparam logic [2:0] LAYER_NEXT   = 3'd6;
   localparam logic [2:0] LAYER_DONE   = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE   = LAYER_IDLE,
      ST_FETCH  = LAYER_FETCH,
      ST_HIDDEN = LAYER_HIDDEN,
      ST_OUTPUT = LAYER_OUTPUT,
      ST_ARGMAX = LAYER_ARGMAX,
      ST_SCORE  = LAYER_SCORE,
      ST_NEXT   = LAYER_NEXT,
      ST_DONE   = LAYER_DONE
   } state_t;

endpackage

// File: rtl/mlp_controller_onehot_sequencer.sv
// One-hot neuron pointer for the hidden layer. The register always holds
// exactly one set bit; bit 0 means neuron index 0. Each enabled cycle the
// bit rotates one position up, wrapping back to bit 0 after the last neuron.
// Needs size_of_hidden_layer >= 2.
module onehot_sequencer #(
   parameter int size_of_hidden_layer = 30
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            en,
   input  logic                            clear,
   output logic [size_of_hidden_layer-1:0] onehot,
   output logic                            last
);

   localparam int H = size_of_hidden_layer;

   logic [H-1:0] ptr;

   // Rotate the pointer on enable; clear or reset parks it on neuron 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= H'(1);
      end else if (clear) begin
         ptr <= H'(1);
      end else if (en) begin
         ptr <= {ptr[H-2:0], ptr[H-1]};
      end
   end

   // Expose the pointer and flag the final hidden neuron.
   always_comb begin
      onehot = ptr;
      last   = ptr[H-1];
   end

endmodule

// File: rtl/mlp_controller.sv
// Control FSM in front of the MLP datapath. Per test vector it walks
// FETCH, one HIDDEN cycle per neuron, OUTPUT, ARGMAX, SCORE and NEXT, then
// loops until the last address has been processed and parks in DONE.
// hold freezes everything; SCORE and inc_addr are masked while held so the
// wrapper's counters never see a stretched pulse.
module mlp_controller
   import mlp_defs::*;
#(
   parameter int size_of_hidden_layer       = 30,
   parameter int number_of_test_cases       = 750,
   parameter int clog2_number_of_test_cases = 10
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic                                  hold,
   input  logic [clog2_number_of_test_cases-1:0] addr_cnt,
   output logic [2:0]                            curr_layer,
   output logic [size_of_hidden_layer+1:0]       ld_en,
   output logic                                  inc_addr,
   output logic                                  busy,
   output logic                                  done
);

   localparam int H = size_of_hidden_layer;
   localparam int C = clog2_number_of_test_cases;
   localparam logic [C-1:0] LAST_ADDR = C'(number_of_test_cases - 1);

   state_t       state;
   state_t       next_state;
   logic [H-1:0] neuron_onehot;
   logic         neuron_last;
   logic         seq_en;
   logic         seq_clear;

   // The neuron pointer only moves in unheld HIDDEN cycles and sits on
   // neuron 0 whenever the FSM is elsewhere.
   always_comb begin
      seq_en    = (state == ST_HIDDEN) && !hold;
      seq_clear = (state != ST_HIDDEN);
   end

   onehot_sequencer #(
      .size_of_hidden_layer(H)
   ) u_seq (
      .clk   (clk),
      .rst   (rst),
      .en    (seq_en),
      .clear (seq_clear),
      .onehot(neuron_onehot),
      .last  (neuron_last)
   );

   // State register; reset aborts any run straight back to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Phase sequencing; a held cycle never moves the FSM.
   always_comb begin
      next_state = state;
      if (!hold) begin
         case (state)
            ST_IDLE:   if (start) next_state = ST_FETCH;
            ST_FETCH:  next_state = ST_HIDDEN;
            ST_HIDDEN: if (neuron_last) next_state = ST_OUTPUT;
            ST_OUTPUT: next_state = ST_ARGMAX;
            ST_ARGMAX: next_state = ST_SCORE;
            ST_SCORE:  next_state = ST_NEXT;
            ST_NEXT:   next_state = (addr_cnt == LAST_ADDR) ? ST_DONE : ST_FETCH;
            ST_DONE:   next_state = ST_DONE;
            default:   next_state = ST_IDLE;
         endcase
      end
   end

   // Output decode from the registered state. A held SCORE cycle reports
   // ARGMAX (with no strobe) so the wrapper's correct-counter samples once.
   always_comb begin
      curr_layer = state;
      ld_en      = '0;
      inc_addr   = 1'b0;
      busy       = (state != ST_IDLE) && (state != ST_DONE);
      done       = (state == ST_DONE);
      case (state)
         ST_HIDDEN: ld_en[H-1:0] = neuron_onehot;
         ST_OUTPUT: ld_en[H]     = 1'b1;
         ST_ARGMAX: ld_en[H+1]   = 1'b1;
         ST_SCORE:  if (hold) curr_layer = LAYER_ARGMAX;
         ST_NEXT:   inc_addr = !hold;
         default:   ld_en = '0;
      endcase
   end

endmodule

// File: tb/tb_mlp_controller.sv
// Bench for mlp_controller: a phase-list reference model predicts every
// cycle's outputs, a monitor compares them on the falling edge, and a
// second instance at default sizes measures the full-run latency.
module tb_mlp_controller;

   localparam int H = 4;
   localparam int N = 3;
   localparam int C = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          hold;
   logic [C-1:0]  addr_cnt;
   logic [2:0]    curr_layer;
   logic [H+1:0]  ld_en;
   logic          inc_addr;
   logic          busy;
   logic          done;

   logic          rst2;
   logic          start2;
   logic          hold2;
   logic [9:0]    addr2;
   logic [2:0]    layer2;
   logic [31:0]   ld_en2;
   logic          inc2;
   logic          busy2;
   logic          done2;

   typedef struct {
      int layer;
      int idx;
   } phase_t;

   typedef struct {
      int           layer;
      bit           score_held;
      logic [H+1:0] ld;
      bit           inc;
      bit           busy;
      bit           done;
   } exp_t;

   phase_t plan[$];
   exp_t   expq[$];
   int     mode;
   int     total = 0;
   int     bad = 0;
   int     inc_seen = 0;
   int     score_seen = 0;
   bit     d2_finished = 1'b0;

   always #5 clk = ~clk;

   mlp_controller #(
      .size_of_hidden_layer(H),
      .number_of_test_cases(N),
      .clog2_number_of_test_cases(C)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .addr_cnt(addr_cnt),
      .curr_layer(curr_layer), .ld_en(ld_en), .inc_addr(inc_addr),
      .busy(busy), .done(done)
   );

   mlp_controller dut_dflt (
      .clk(clk), .rst(rst2), .start(start2), .hold(hold2), .addr_cnt(addr2),
      .curr_layer(layer2), .ld_en(ld_en2), .inc_addr(inc2),
      .busy(busy2), .done(done2)
   );

   // Wrapper address counters driven by inc_addr.
   always @(posedge clk or negedge rst) begin
      if (!rst) addr_cnt <= '0;
      else if (inc_addr) addr_cnt <= addr_cnt + 1'b1;
   end

   always @(posedge clk or negedge rst2) begin
      if (!rst2) addr2 <= '0;
      else if (inc2) addr2 <= addr2 + 1'b1;
   end

   task automatic checkOutput(input string nm, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   function automatic exp_t mkExp(int layer, int idx, bit hd);
      exp_t e;
      e.layer      = layer;
      e.score_held = (layer == 5) && hd;
      e.ld         = '0;
      if (layer == 2) e.ld[idx] = 1'b1;
      if (layer == 3) e.ld[H] = 1'b1;
      if (layer == 4) e.ld[H+1] = 1'b1;
      e.inc  = (layer == 6) && !hd;
      e.busy = (layer >= 1) && (layer <= 6);
      e.done = (layer == 7);
      return e;
   endfunction

   function automatic void buildPlan();
      plan.delete();
      for (int v = 0; v < N; v++) begin
         plan.push_back('{1, 0});
         for (int i = 0; i < H; i++) plan.push_back('{2, i});
         plan.push_back('{3, 0});
         plan.push_back('{4, 0});
         plan.push_back('{5, 0});
         plan.push_back('{6, 0});
      end
   endfunction

   // One clock cycle of stimulus: drive inputs, predict this cycle's outputs,
   // then advance the model as the coming edge will.
   task automatic applyStimulus(input bit r, input bit st, input bit hd);
      int layer;
      int idx;
      @(posedge clk);
      #1;
      rst   = r;
      start = st;
      hold  = hd;
      if (!r) begin
         mode = 0;
         plan.delete();
      end
      layer = (mode == 0) ? 0 : (mode == 2) ? 7 : plan[0].layer;
      idx   = (mode == 1) ? plan[0].idx : 0;
      expq.push_back(mkExp(layer, idx, hd));
      if (r && !hd) begin
         if (mode == 0 && st) begin
            buildPlan();
            mode = 1;
         end else if (mode == 1) begin
            void'(plan.pop_front());
            if (plan.size() == 0) mode = 2;
         end
      end
   endtask

   task automatic advanceTo(input int layer, input int idx);
      bit hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (mode == 1 && plan[0].layer == layer && plan[0].idx == idx) begin
            hit = 1'b1;
            break;
         end
         applyStimulus(1, 0, 0);
      end
      checkOutput("reach_phase", hit, 1);
   endtask

   task automatic finishRun(input bit use_hold);
      for (int k = 0; k < 2000 && mode != 2; k++) begin
         applyStimulus(1, $urandom_range(0, 4) == 0,
                       use_hold && ($urandom_range(0, 3) == 0));
      end
      checkOutput("run_reaches_done", mode, 2);
      for (int k = 0; k < 4; k++) applyStimulus(1, $urandom_range(0, 1) == 1, 0);
      checkOutput("inc_addr_pulses", inc_seen, N);
      checkOutput("score_cycles", score_seen, N);
   endtask

   // Monitor: every cycle the DUT outputs are set against the oldest prediction.
   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         if (e.score_held) begin
            total++;
            if (curr_layer == 3'd5) begin
               bad++;
               $display("[TB] FAIL held_score_layer: got %0d, required not 5 at %0t",
                        curr_layer, $time);
            end
         end else begin
            checkOutput("curr_layer", curr_layer, e.layer);
         end
         checkOutput("ld_en", ld_en, e.ld);
         checkOutput("inc_addr", inc_addr, e.inc);
         checkOutput("busy", busy, e.busy);
         checkOutput("done", done, e.done);
      end
      if (inc_addr) inc_seen++;
      if (curr_layer == 3'd5) score_seen++;
   end

   // Default-size instance: done must come 750*35 cycles after the first FETCH.
   initial begin
      int  cnt;
      bit  found;
      bit  got;
      rst2 = 1'b0;
      start2 = 1'b0;
      hold2 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b1;
      @(posedge clk);
      #1 start2 = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (layer2 == 3'd1) begin
            found = 1'b1;
            break;
         end
      end
      checkOutput("dflt_first_fetch", found, 1);
      cnt = 0;
      got = 1'b0;
      for (int k = 0; k < 30000; k++) begin
         @(negedge clk);
         cnt++;
         if (done2) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput("dflt_done_seen", got, 1);
      checkOutput("dflt_done_latency", cnt, 26250);
      checkOutput("dflt_inc_total", addr2, 750);
      d2_finished = 1'b1;
   end

   initial begin
      exp_t e;
      rst = 1'b0;
      start = 1'b0;
      hold = 1'b0;
      mode = 0;

      // Reset state, then start+hold in IDLE must be ignored.
      repeat (3) applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 1);
      applyStimulus(1, 0, 0);

      // Run 1: no holds, stray start pulses while busy and in DONE.
      inc_seen = 0;
      score_seen = 0;
      applyStimulus(1, 1, 0);
      finishRun(0);

      // Run 2: directed holds in HIDDEN bit 2, SCORE and NEXT, then random holds.
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      inc_seen = 0;
      score_seen = 0;
      applyStimulus(1, 1, 0);
      advanceTo(2, 2);
      repeat (5) applyStimulus(1, 0, 1);
      advanceTo(5, 0);
      repeat (2) applyStimulus(1, 1, 1);
      advanceTo(6, 0);
      repeat (3) applyStimulus(1, 0, 1);
      finishRun(1);

      // Run 3: asynchronous reset in the middle of HIDDEN, then restart.
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 0);
      advanceTo(2, 1);
      applyStimulus(1, 0, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("async_rst_layer", curr_layer, 0);
      checkOutput("async_rst_ld_en", ld_en, 0);
      checkOutput("async_rst_busy", busy, 0);
      checkOutput("async_rst_inc", inc_addr, 0);
      mode = 0;
      plan.delete();
      e = mkExp(0, 0, 0);
      expq.push_back(e);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      inc_seen = 0;
      score_seen = 0;
      applyStimulus(1, 1, 0);
      finishRun(1);

      for (int k = 0; k < 40000 && !d2_finished; k++) @(posedge clk);
      checkOutput("dflt_instance_finished", d2_finished, 1);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
